// File: rtl/test_stub_mbist_ctl.sv
// Memory-BIST control stub: takes BIST control bits from a CSR write or from the
// CTU serial enable line, runs one BIST pass and collects per-array sticky fail flags,
// a run watchdog and a saturating fail-cycle counter.
module test_stub_mbist_ctl #(
  parameter int unsigned NUM_ARRAYS     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16,
  parameter int unsigned FCNT_W         = 8
) (
  input  logic                    rclk,
  input  logic                    cluster_grst,
  input  logic                    ctu_tst_mbist_enable,
  input  logic [6:0]              bist_ctl_reg_in,
  input  logic                    bist_ctl_reg_wr_en,
  input  logic                    mbist_done,
  input  logic [NUM_ARRAYS-1:0]   mbist_err,
  output logic [NUM_ARRAYS+8:0]   bist_ctl_reg_out,
  output logic                    mbist_bisi_mode,
  output logic                    mbist_stop_on_next_fail,
  output logic                    mbist_stop_on_fail,
  output logic                    mbist_loop_mode,
  output logic                    mbist_loop_on_addr,
  output logic                    mbist_data_mode,
  output logic                    mbist_start,
  output logic                    mbist_busy,
  output logic [FCNT_W-1:0]       mbist_fail_cnt,
  output logic                    tst_ctu_mbist_done,
  output logic                    tst_ctu_mbist_fail
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [TO_W-1:0] TcntLast = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [6:0]            ctl_q, ctl_d;
  logic [NUM_ARRAYS-1:0] fail_q, fail_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic                  en_d1_q, en_d2_q;
  logic                  arm_q, arm_d;
  logic                  busy_q, busy_d;
  logic                  flag_q, flag_d;

  logic en_rise;
  logic wr_start;
  logic wr_stop;
  logic clr_status;

  // arm_q blocks a pseudo-edge when the enable line is already high as reset releases:
  // a rise only counts once the line has been seen low since reset.
  assign en_rise  = en_d1_q & ~en_d2_q & arm_q;
  assign wr_start = bist_ctl_reg_wr_en & bist_ctl_reg_in[0];
  assign wr_stop  = bist_ctl_reg_wr_en & ~bist_ctl_reg_in[0];

  // Next-state and status update for the BIST sequencer
  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    fail_d     = fail_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    fcnt_d     = fcnt_q;
    tcnt_d     = tcnt_q;
    bitcnt_d   = bitcnt_q;
    clr_status = 1'b0;
    arm_d      = arm_q | ~ctu_tst_mbist_enable;

    unique case (state_q)
      StIdle, StDone: begin
        // CSR write wins over a serial edge
        if (wr_start) begin
          ctl_d      = bist_ctl_reg_in;
          clr_status = 1'b1;
          state_d    = StRun;
        end else if (wr_stop) begin
          ctl_d = bist_ctl_reg_in;
        end else if (en_rise) begin
          ctl_d      = '0;
          clr_status = 1'b1;
          bitcnt_d   = 3'd0;
          state_d    = StShift;
        end
      end
      StShift: begin
        // First bit shifted in ends up in ctl[6]; start is set with the sixth shift
        ctl_d    = {ctl_q[5:1], en_d1_q, (bitcnt_q == 3'd5)};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd5) begin
          state_d = StRun;
        end
      end
      StRun: begin
        fail_d = fail_q | mbist_err;
        tcnt_d = tcnt_q + TO_W'(1);
        if ((|mbist_err) && (fcnt_q != '1)) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
        if (wr_stop) begin
          ctl_d   = bist_ctl_reg_in;
          state_d = StIdle;
        end else if (mbist_done) begin
          ctl_d[0] = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (tcnt_q == TcntLast) begin
          ctl_d[0]  = 1'b0;
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_status) begin
      fail_d    = '0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      fcnt_d    = '0;
      tcnt_d    = '0;
    end

    busy_d = (state_d == StShift) || (state_d == StRun);
    flag_d = (|fail_d) | timeout_d;
  end

  // State, status and enable-sync registers with synchronous reset
  always_ff @(posedge rclk) begin
    if (cluster_grst) begin
      state_q   <= StIdle;
      ctl_q     <= '0;
      fail_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      fcnt_q    <= '0;
      tcnt_q    <= '0;
      bitcnt_q  <= 3'd0;
      en_d1_q   <= 1'b0;
      en_d2_q   <= 1'b0;
      arm_q     <= 1'b0;
      busy_q    <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      fcnt_q    <= fcnt_d;
      tcnt_q    <= tcnt_d;
      bitcnt_q  <= bitcnt_d;
      en_d1_q   <= ctu_tst_mbist_enable;
      en_d2_q   <= en_d1_q;
      arm_q     <= arm_d;
      busy_q    <= busy_d;
      flag_q    <= flag_d;
    end
  end

  assign bist_ctl_reg_out        = {timeout_q, done_q, fail_q, ctl_q};
  assign mbist_bisi_mode         = ctl_q[6];
  assign mbist_stop_on_next_fail = ctl_q[5];
  assign mbist_stop_on_fail      = ctl_q[4];
  assign mbist_loop_mode         = ctl_q[3];
  assign mbist_loop_on_addr      = ctl_q[2];
  assign mbist_data_mode         = ctl_q[1];
  assign mbist_start             = ctl_q[0];
  assign mbist_busy              = busy_q;
  assign mbist_fail_cnt          = fcnt_q;
  assign tst_ctu_mbist_done      = done_q;
  assign tst_ctu_mbist_fail      = flag_q;

endmodule

// File: tb/tb_test_stub_mbist_ctl.sv
// Directed bench for test_stub_mbist_ctl with small timeout and fail-counter widths.
module tb_test_stub_mbist_ctl;

  localparam int unsigned NA = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [6:0]    din;
  logic          wr;
  logic          done;
  logic [NA-1:0] err;
  logic [NA+8:0] out;
  logic          bisi, sonf, sof, loopm, loopa, datam, start, busy;
  logic [3:0]    fcnt;
  logic          tdone, tfail;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  test_stub_mbist_ctl #(
    .NUM_ARRAYS     (NA),
    .TIMEOUT_CYCLES (16),
    .TO_W           (5),
    .FCNT_W         (4)
  ) dut (
    .rclk                    (clk),
    .cluster_grst            (rst),
    .ctu_tst_mbist_enable    (en),
    .bist_ctl_reg_in         (din),
    .bist_ctl_reg_wr_en      (wr),
    .mbist_done              (done),
    .mbist_err               (err),
    .bist_ctl_reg_out        (out),
    .mbist_bisi_mode         (bisi),
    .mbist_stop_on_next_fail (sonf),
    .mbist_stop_on_fail      (sof),
    .mbist_loop_mode         (loopm),
    .mbist_loop_on_addr      (loopa),
    .mbist_data_mode         (datam),
    .mbist_start             (start),
    .mbist_busy              (busy),
    .mbist_fail_cnt          (fcnt),
    .tst_ctu_mbist_done      (tdone),
    .tst_ctu_mbist_fail      (tfail)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, 32'(out), 32'h000);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fcnt"}, 32'(fcnt), 32'd0);
    chk({tag, "_tdone"}, 32'(tdone), 32'd0);
    chk({tag, "_tfail"}, 32'(tfail), 32'd0);
  endtask

  initial begin
    logic [5:0] bits;
    rst = 1'b1; en = 1'b0; din = 7'h00; wr = 1'b0; done = 1'b0; err = '0;
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // CSR start with errors on array 1, then done
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0;
    chk("csr_out", 32'(out), 32'h003);
    chk("csr_start", 32'(start), 32'd1);
    chk("csr_busy", 32'(busy), 32'd1);
    err = 3'b010;
    tick(1);
    chk("csr_err1_out", 32'(out), 32'h103);
    chk("csr_err1_fcnt", 32'(fcnt), 32'd1);
    tick(1);
    err = 3'b000; done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("csr_done_out", 32'(out), 32'h502);
    chk("csr_done_fcnt", 32'(fcnt), 32'd2);
    chk("csr_done_tfail", 32'(tfail), 32'd1);
    chk("csr_done_tdone", 32'(tdone), 32'd1);
    chk("csr_done_busy", 32'(busy), 32'd0);
    chk("csr_done_start", 32'(start), 32'd0);
    chk("csr_done_datam", 32'(datam), 32'd1);

    // Serial setup: rise, then 1,0,1,1,0,1
    bits = 6'b101101;
    en = 1'b1;
    tick(1);
    en = bits[5];
    tick(1);
    chk("ser_enter_busy", 32'(busy), 32'd1);
    chk("ser_enter_out", 32'(out), 32'h000);
    for (int i = 4; i >= 0; i--) begin
      en = bits[i];
      tick(1);
    end
    chk("ser_mid_start", 32'(start), 32'd0);
    chk("ser_mid_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick(1);
    chk("ser_run_out", 32'(out), 32'h05B);
    chk("ser_run_start", 32'(start), 32'd1);
    chk("ser_modes", 32'({bisi, sonf, sof, loopm, loopa, datam}), 32'h2D);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("ser_done_out", 32'(out), 32'h45A);
    chk("ser_done_tdone", 32'(tdone), 32'd1);
    chk("ser_done_tfail", 32'(tfail), 32'd0);

    // Watchdog: 16 RUN cycles without done
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0;
    tick(15);
    chk("to_pre_start", 32'(start), 32'd1);
    tick(1);
    chk("to_out", 32'(out), 32'h802);
    chk("to_start", 32'(start), 32'd0);
    chk("to_tdone", 32'(tdone), 32'd0);
    chk("to_tfail", 32'(tfail), 32'd1);

    // Abort on RUN cycle 5
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0;
    tick(4);
    wr = 1'b1; din = 7'h00;
    tick(1);
    wr = 1'b0;
    chk("abort_out", 32'(out), 32'h000);
    chk("abort_busy", 32'(busy), 32'd0);

    // Abort coincident with done: abort wins
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0;
    tick(2);
    wr = 1'b1; din = 7'h00; done = 1'b1;
    tick(1);
    wr = 1'b0; done = 1'b0;
    chk("abort_done_out", 32'(out), 32'h000);
    chk("abort_done_tdone", 32'(tdone), 32'd0);
    chk("abort_done_busy", 32'(busy), 32'd0);

    // Done on the timeout cycle: done wins
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0;
    tick(15);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("done_vs_to_out", 32'(out), 32'h402);

    // Fail counter saturation; errors keep flowing after the run ends
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0;
    err = 3'b101;
    tick(15);
    chk("sat15_fcnt", 32'(fcnt), 32'hF);
    tick(5);
    err = 3'b000;
    chk("sat20_fcnt", 32'(fcnt), 32'hF);
    chk("sat20_out", 32'(out), 32'hA82);

    // Reset during SHIFT, enable then held high
    en = 1'b1;
    tick(2);
    chk("rs_shift_busy", 32'(busy), 32'd1);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk_all_zero("rst_shift");
    rst = 1'b0;
    tick(4);
    chk("rs_hold_busy", 32'(busy), 32'd0);
    chk("rs_hold_out", 32'(out), 32'h000);

    // Reset during RUN, enable raised with reset and held
    en = 1'b0;
    tick(1);
    wr = 1'b1; din = 7'h03;
    tick(1);
    wr = 1'b0; err = 3'b001;
    tick(1);
    chk("rr_run_start", 32'(start), 32'd1);
    rst = 1'b1; en = 1'b1; err = 3'b000;
    tick(1);
    chk_all_zero("rst_run");
    rst = 1'b0;
    tick(4);
    chk("rr_hold_busy", 32'(busy), 32'd0);

    // A fresh low-to-high transition still starts a serial setup
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(2);
    chk("rearm_busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/test_stub_mbist_ctl.md
Name: test_stub_mbist_ctl

Overview:
Parametrised memory-BIST control stub for a tile cluster. It accepts BIST control bits either from a software CSR write or from the CTU serial enable pin. It sequences one BIST run through an explicit state machine and collects per-array sticky fail flags. New behaviour:
- N arrays
- run timeout watchdog
- saturating fail-cycle counter
- software abort

Parameters:
NUM_ARRAYS, 3, number of arrays reporting mbist_err (1..16)
TIMEOUT_CYCLES, 65535, RUN cycles before watchdog fires (>=2)
TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES
FCNT_W, 8, fail-cycle counter width

Ports:
rclk  in  1  clock
cluster_grst  in  1  reset, synchronous, active-high
ctu_tst_mbist_enable  in  1  CTU serial setup line
bist_ctl_reg_in  in  7  CSR write data, control bits [6:0]
bist_ctl_reg_wr_en  in  1  CSR write strobe
mbist_done  in  1  BIST engine done pulse/level
mbist_err  in  NUM_ARRAYS  per-array error
bist_ctl_reg_out  out  NUM_ARRAYS+9  CSR readback: [6:0] ctl, [6+N:7] sticky fail, [7+N] done, [8+N] timeout
mbist_bisi_mode, mbist_stop_on_next_fail, mbist_stop_on_fail, mbist_loop_mode, mbist_loop_on_addr, mbist_data_mode  out  1 each  = ctl[6:1]
mbist_start  out  1  = ctl[0]; high only in RUN
mbist_busy  out  1  state is SHIFT or RUN
mbist_fail_cnt  out  FCNT_W  cycles in RUN with any err bit high, saturating
tst_ctu_mbist_done  out  1  = done flag
tst_ctu_mbist_fail  out  1  = (|sticky fail) | timeout

Behaviour:
- All outputs are registered. Synchronous reset on cluster_grst:
  - state = IDLE
  - ctl, fail, done, timeout, counters = 0
  - en_d1 and en_d2 (two delay flops on ctu_tst_mbist_enable) = 0
- edge = en_d1 & ~en_d2.
- States: IDLE, SHIFT, RUN, DONE. State and flag updates take effect on the cycle after the triggering condition.
- IDLE:
  - wr_en with in[0]=1: load ctl <= in; clear fail/done/timeout/fcnt/tcnt; go to RUN.
  - wr_en with in[0]=0: load ctl; stay in IDLE.
  - Otherwise, if edge: clear ctl and status; bitcnt=0; go to SHIFT.
  - wr_en has priority over edge.
- SHIFT:
  - Each cycle: ctl[6:1] <= {ctl[5:1], en_d1}; bitcnt++.
  - After 6 shifts (bitcnt==5 on the last shift), go to RUN with ctl[0]=1.
  - Shift order: the first bit sampled after the edge ends in ctl[6] (bisi); the last ends in ctl[1].
  - CSR writes are ignored in SHIFT. mbist_start stays 0.
- RUN:
  - mbist_start=1. tcnt increments each cycle.
  - fail[i] |= mbist_err[i].
  - fcnt increments (saturating at all-ones) when |mbist_err.
  - mbist_done=1: go to DONE; ctl[0]<=0; done<=1.
  - Otherwise, if tcnt==TIMEOUT_CYCLES-1: go to DONE; ctl[0]<=0; timeout<=1; done stays 0.
  - Done and timeout in the same cycle: done wins, timeout=0.
  - wr_en with in[0]=0 (abort): go to IDLE; ctl<=in; done and timeout unchanged; abort has priority over done.
  - wr_en with in[0]=1 in RUN is ignored.
  - Errors sampled in the cycle mbist_done is seen are still accumulated.
- DONE:
  - Status holds.
  - wr_en with in[0]=1 restarts exactly as from IDLE.
  - wr_en with in[0]=0 loads ctl and stays in DONE.
  - edge goes to SHIFT and clears status.
- Reset asserted mid-SHIFT or mid-RUN returns to IDLE next cycle with all flags cleared; mbist_start drops the same edge.
- mbist_err outside RUN is ignored.
- ctu_tst_mbist_enable held high does not retrigger; a new low-to-high transition is required.

Test Plan:
- Reset, then CSR write 7'h03: next cycle state RUN, mbist_start=1, busy=1. mbist_err=3'b010 for 2 cycles, then mbist_done: bist_ctl_reg_out = 12'h502 (start cleared, fail[1]=1, done=1), fail_cnt=2, tst_ctu_mbist_fail=1.
- Serial setup: enable rises, then bit sequence 1,0,1,1,0,1 on following cycles: ctl[6:1]=6'b101101, start=1 after the 6th shift. mbist_done with no errors: tst_ctu_mbist_done=1, fail=0.
- Timeout (TIMEOUT_CYCLES=16): CSR start with no mbist_done: after 16 RUN cycles start=0, timeout bit[11]=1, done=0, tst_ctu_mbist_fail=1.
- Abort: start via CSR, write 7'h00 on RUN cycle 5: IDLE, start=0, done=0. Same abort coincident with mbist_done: IDLE, done=0.
- Fail counter saturation (FCNT_W=4): 20 cycles of mbist_err!=0 in RUN -> fail_cnt=4'hF.
- Reset asserted during SHIFT and separately during RUN: next cycle all outputs 0; enable held high afterwards causes no SHIFT entry.
